byte_mem_arbiter: RTL and testbench
===================================

BYTE_MEM_ARBITER -- requirements
Module: byte_mem_arbiter

Interface
- REQ-001 SHALL have parameter: ADDR_WIDTH, 32, address width of all three bus_if ports.
- REQ-002 SHALL have parameter: MAX_OUTSTANDING, 4, maximum reads in flight on mem; at most 15.
- REQ-003 SHALL have port: clk  in  1  single clock for all logic and ports.
- REQ-004 SHALL have port: reset  in  1  synchronous, active-high reset.
- REQ-005 SHALL have port: req_a  in  1  requester A wants the memory port; highest priority after reset.
- REQ-006 SHALL have port: gnt_a  out  1  requester A owns mem.
- REQ-007 SHALL have port: bus_a  bus_if slave  8-bit data  requester A byte bus.
- REQ-008 SHALL have port: req_b  in  1  requester B wants the memory port.
- REQ-009 SHALL have port: gnt_b  out  1  requester B owns mem.
- REQ-010 SHALL have port: bus_b  bus_if slave  8-bit data  requester B byte bus.
- REQ-011 SHALL have port: mem  bus_if master  8-bit data  shared byte memory.
- REQ-012 SHALL have port: err  out  1  single-cycle protocol-violation pulse.

Function
- REQ-013 SHALL implement FSM states IDLE, OWN_A, OWN_B, DRAIN, with owner register owner_q in {A,B}.
- REQ-014 IDLE, req_a only: SHALL go to OWN_A next cycle. IDLE, req_b only: SHALL go to OWN_B. Both requested: SHALL grant the requester not equal to last_q, the last-served requester, which resets to B.
- REQ-015 gnt_a SHALL be 1 exactly in OWN_A; gnt_b SHALL be 1 exactly in OWN_B; both are registered, so grant latency from req in IDLE is 1 cycle.
- REQ-016 In OWN_x, mem.addr/wr_data/rd/wr SHALL combinationally follow bus_x; outside OWN_x, mem.rd = mem.wr = 0, and mem.addr/wr_data hold the last owner's values.
- REQ-017 In OWN_x, when req_x = 0: SHALL go to IDLE if the outstanding count is 0 and no mem.rd is issued this cycle, else to DRAIN; last_q <= x.
- REQ-018 DRAIN SHALL exit to IDLE on the cycle the outstanding count reaches 0; no grant SHALL be asserted in DRAIN.
- REQ-019 The outstanding count SHALL increment on mem.rd = 1 and decrement on mem.rd_data_valid = 1; simultaneous increment and decrement SHALL leave it unchanged.
- REQ-020 bus_a.rd_data and bus_b.rd_data SHALL both equal mem.rd_data.
- REQ-021 bus_x.rd_data_valid SHALL equal mem.rd_data_valid while owner_q = x, in OWN_x or DRAIN.
- REQ-022 When the outstanding count equals MAX_OUTSTANDING and the owner asserts rd, SHALL suppress mem.rd for that cycle and pulse err; the count SHALL NOT wrap.
- REQ-023 SHALL pulse err and ignore the access when rd or wr is asserted by a non-owner.
- REQ-024 SHALL pulse err when mem.rd_data_valid arrives with count 0, with no decrement and no forwarding.
- REQ-025 If rd and wr are asserted together by the owner, mem.rd and mem.wr SHALL both forward unchanged and err SHALL pulse.
- REQ-026 err SHALL be registered, giving 1-cycle latency from the violation.

Reset
- REQ-027 On reset = 1 at a clock edge, SHALL set state = IDLE, gnt_a = gnt_b = 0, count = 0, err = 0, last_q = B, owner_q = A.
- REQ-028 Reset mid-transaction SHALL abandon in-flight reads; any mem.rd_data_valid after reset SHALL be treated per REQ-024.
- REQ-029 mem.rd and mem.wr SHALL be 0 during and on the first cycle after reset.

Verification
- REQ-030 req_a = req_b = 1 from IDLE after reset -> gnt_a = 1 next cycle; req_a drops with count 0 -> IDLE, then gnt_b = 1 one cycle later.
- REQ-031 A owner issues 4 rd beats (addr 0x100..0x103), drops req_a, memory returns 4 valids 3 cycles later -> DRAIN until the 4th valid, bus_a sees 4 valids, bus_b none, then IDLE.
- REQ-032 B owner issues 5 back-to-back rd with MAX_OUTSTANDING = 4 and no returns -> 5th mem.rd suppressed, err = 1 for exactly 1 cycle, count stays 4.
- REQ-033 A owns mem, bus_b.wr = 1 with addr 0x20 -> mem.wr reflects only A, err pulses once.
- REQ-034 Reset asserted in DRAIN with count 2, then 1 stray mem.rd_data_valid -> IDLE, no grants, no forwarded valid, err pulses once.
- REQ-035 A owner writes bytes 0x11,0x22,0x33,0x44 to addr 0x0..0x3 -> mem.wr high 4 cycles with matching addr/data, count stays 0.

Source files
------------

// File: rtl/bus_if.sv
// Byte-wide memory bus: address, write data, read/write strobes,
// read data with a valid strobe returning some cycles later.
interface bus_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            wr_data;
  logic                  rd;
  logic                  wr;
  logic [7:0]            rd_data;
  logic                  rd_data_valid;

  modport master (
    output addr, wr_data, rd, wr,
    input  rd_data, rd_data_valid
  );

  modport slave (
    input  addr, wr_data, rd, wr,
    output rd_data, rd_data_valid
  );
endinterface

// File: rtl/byte_mem_arbiter.sv
// Two-requester arbiter for one shared byte memory port with
// outstanding-read tracking, drain on release and error pulses.
module byte_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  req_a,
  output logic  gnt_a,
  bus_if.slave  bus_a,
  input  logic  req_b,
  output logic  gnt_b,
  bus_if.slave  bus_b,
  bus_if.master mem,
  output logic  err
);

  typedef enum logic [1:0] {
    IDLE, OWN_A, OWN_B, DRAIN
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            wdata_q;

  logic sel_a, sel_b, drain;
  logic full, own_rd, own_wr;
  logic rd_go, dec, viol;

  always_comb begin
    sel_a  = (state_q == OWN_A);
    sel_b  = (state_q == OWN_B);
    drain  = (state_q == DRAIN);
    full   = (cnt_q == MAX_CNT);
    own_rd = (sel_a & bus_a.rd) | (sel_b & bus_b.rd);
    own_wr = (sel_a & bus_a.wr) | (sel_b & bus_b.wr);
    rd_go  = own_rd & ~full & ~reset;
    // a valid with nothing in flight is stray: never counted
    dec    = mem.rd_data_valid & (cnt_q != 4'd0);
    viol   = (own_rd & full)
           | (own_rd & own_wr)
           | (~sel_a & (bus_a.rd | bus_a.wr))
           | (~sel_b & (bus_b.rd | bus_b.wr))
           | (mem.rd_data_valid & (cnt_q == 4'd0));
    cnt_d  = cnt_q + {3'b000, rd_go} - {3'b000, dec};
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        // last_q = 1 means B was served last
        if (req_a && (!req_b || last_q)) begin
          state_d = OWN_A;
          owner_d = 1'b0;
        end else if (req_b) begin
          state_d = OWN_B;
          owner_d = 1'b1;
        end
      end
      OWN_A: begin
        if (!req_a) begin
          last_d  = 1'b0;
          state_d = (cnt_q == 4'd0 && !rd_go) ? IDLE : DRAIN;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          last_d  = 1'b1;
          state_d = (cnt_q == 4'd0 && !rd_go) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_d == 4'd0) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= viol;
      addr_q  <= mem.addr;
      wdata_q <= mem.wr_data;
    end
  end

  assign gnt_a = sel_a;
  assign gnt_b = sel_b;
  assign err   = err_q;

  assign mem.rd      = rd_go;
  assign mem.wr      = own_wr & ~reset;
  assign mem.addr    = sel_a ? bus_a.addr
                     : sel_b ? bus_b.addr
                     : addr_q;
  assign mem.wr_data = sel_a ? bus_a.wr_data
                     : sel_b ? bus_b.wr_data
                     : wdata_q;

  assign bus_a.rd_data = mem.rd_data;
  assign bus_b.rd_data = mem.rd_data;
  assign bus_a.rd_data_valid =
    dec & ~owner_q & (sel_a | drain);
  assign bus_b.rd_data_valid =
    dec & owner_q & (sel_b | drain);

endmodule

// File: tb/tb_byte_mem_arbiter.sv
// Directed bench for byte_mem_arbiter: arbitration, drain,
// outstanding limit, error pulses and reset behaviour.
module tb_byte_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic req_a, req_b;
  logic gnt_a, gnt_b, err;

  int n_assert = 0;
  int n_fail   = 0;

  bus_if #(.ADDR_WIDTH(32)) bus_a ();
  bus_if #(.ADDR_WIDTH(32)) bus_b ();
  bus_if #(.ADDR_WIDTH(32)) mem ();

  byte_mem_arbiter #(
    .ADDR_WIDTH     (32),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req_a(req_a),
    .gnt_a(gnt_a),
    .bus_a(bus_a),
    .req_b(req_b),
    .gnt_b(gnt_b),
    .bus_b(bus_b),
    .mem  (mem),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    bus_a.addr = '0; bus_a.wr_data = '0;
    bus_a.rd = 1'b0; bus_a.wr = 1'b0;
    bus_b.addr = '0; bus_b.wr_data = '0;
    bus_b.rd = 1'b0; bus_b.wr = 1'b0;
    mem.rd_data = '0;
    mem.rd_data_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_gnt_a", gnt_a, 0);
    check("rst_gnt_b", gnt_b, 0);
    check("rst_err", err, 0);
    check("rst_mem_rd", mem.rd, 0);
    check("rst_mem_wr", mem.wr, 0);
    check("rst_cnt", dut.cnt_q, 0);

    // both request after reset: A first, then B
    req_a = 1'b1; req_b = 1'b1;
    tick();
    check("arb_gnt_a", gnt_a, 1);
    check("arb_gnt_b0", gnt_b, 0);
    req_a = 1'b0;
    tick();
    check("rel_gnt_a", gnt_a, 0);
    check("rel_gnt_b", gnt_b, 0);
    tick();
    check("next_gnt_b", gnt_b, 1);
    req_b = 1'b0;
    tick();
    check("idle_gnt_b", gnt_b, 0);

    // A writes four bytes
    req_a = 1'b1;
    tick();
    check("wr_gnt_a", gnt_a, 1);
    for (int i = 0; i < 4; i++) begin
      bus_a.wr = 1'b1;
      bus_a.addr = 32'(i);
      bus_a.wr_data = 8'(8'h11 * (i + 1));
      #1;
      check("wr_mem_wr", mem.wr, 1);
      check("wr_mem_addr", mem.addr, i);
      check("wr_mem_data", mem.wr_data, 8'h11 * (i + 1));
      check("wr_mem_rd", mem.rd, 0);
      tick();
      check("wr_err", err, 0);
    end
    bus_a.wr = 1'b0;
    #1;
    check("wr_done", mem.wr, 0);
    check("wr_cnt", dut.cnt_q, 0);

    // B writes while A owns: ignored, error
    bus_b.wr = 1'b1; bus_b.addr = 32'h20;
    bus_b.wr_data = 8'hEE;
    bus_a.wr = 1'b1; bus_a.addr = 32'h5;
    bus_a.wr_data = 8'h55;
    #1;
    check("nown_mem_wr", mem.wr, 1);
    check("nown_addr", mem.addr, 32'h5);
    check("nown_data", mem.wr_data, 8'h55);
    tick();
    check("nown_err", err, 1);
    bus_b.wr = 1'b0;
    bus_a.wr = 1'b0;
    tick();
    check("nown_err_clr", err, 0);

    // A issues four reads, releases, then drains
    for (int i = 0; i < 4; i++) begin
      bus_a.rd = 1'b1;
      bus_a.addr = 32'h100 + 32'(i);
      #1;
      check("rd_mem_rd", mem.rd, 1);
      check("rd_mem_addr", mem.addr, 32'h100 + i);
      tick();
    end
    bus_a.rd = 1'b0;
    req_a = 1'b0;
    #1;
    check("rd_hold_addr", mem.addr, 32'h103);
    tick();
    check("drain_gnt_a", gnt_a, 0);
    check("drain_cnt", dut.cnt_q, 4);
    tick();
    tick();
    check("drain_wait_gnt", gnt_a | gnt_b, 0);
    check("drain_err", err, 0);
    for (int i = 0; i < 4; i++) begin
      mem.rd_data_valid = 1'b1;
      mem.rd_data = 8'hA0 + 8'(i);
      if (i == 3) req_b = 1'b1;
      #1;
      check("ret_va", bus_a.rd_data_valid, 1);
      check("ret_vb", bus_b.rd_data_valid, 0);
      check("ret_da", bus_a.rd_data, 8'hA0 + i);
      check("ret_db", bus_b.rd_data, 8'hA0 + i);
      check("ret_gnt", gnt_a | gnt_b, 0);
      tick();
    end
    mem.rd_data_valid = 1'b0;
    check("ret_cnt", dut.cnt_q, 0);
    check("ret_err", err, 0);
    check("ret_idle_gnt", gnt_a | gnt_b, 0);
    tick();
    check("ret_gnt_b", gnt_b, 1);

    // B overruns the outstanding limit
    for (int i = 0; i < 5; i++) begin
      bus_b.rd = 1'b1;
      bus_b.addr = 32'h200 + 32'(i);
      #1;
      check("ovf_mem_rd", mem.rd, (i < 4) ? 1 : 0);
      tick();
      check("ovf_err", err, (i == 4) ? 1 : 0);
    end
    bus_b.rd = 1'b0;
    check("ovf_cnt", dut.cnt_q, 4);
    tick();
    check("ovf_err_clr", err, 0);
    check("ovf_cnt_hold", dut.cnt_q, 4);

    // release into drain, return two reads
    req_b = 1'b0;
    tick();
    check("b_drain_gnt", gnt_b, 0);
    for (int i = 0; i < 2; i++) begin
      mem.rd_data_valid = 1'b1;
      mem.rd_data = 8'hC0 + 8'(i);
      #1;
      check("b_ret_vb", bus_b.rd_data_valid, 1);
      check("b_ret_va", bus_a.rd_data_valid, 0);
      tick();
    end
    mem.rd_data_valid = 1'b0;
    check("b_ret_cnt", dut.cnt_q, 2);

    // reset in drain, then a stray valid
    reset = 1'b1;
    #1;
    check("rs_mem_rd", mem.rd, 0);
    tick();
    reset = 1'b0;
    mem.rd_data_valid = 1'b1;
    mem.rd_data = 8'h77;
    #1;
    check("stray_va", bus_a.rd_data_valid, 0);
    check("stray_vb", bus_b.rd_data_valid, 0);
    check("stray_gnt", gnt_a | gnt_b, 0);
    check("stray_mem_rd", mem.rd, 0);
    tick();
    mem.rd_data_valid = 1'b0;
    check("stray_err", err, 1);
    check("stray_cnt", dut.cnt_q, 0);
    tick();
    check("stray_err_clr", err, 0);
    check("stray_idle", gnt_a | gnt_b, 0);

    // owner asserts rd and wr together
    req_a = 1'b1;
    tick();
    check("rw_gnt_a", gnt_a, 1);
    bus_a.rd = 1'b1;
    bus_a.wr = 1'b1;
    bus_a.addr = 32'h40;
    #1;
    check("rw_mem_rd", mem.rd, 1);
    check("rw_mem_wr", mem.wr, 1);
    tick();
    bus_a.rd = 1'b0;
    bus_a.wr = 1'b0;
    check("rw_err", err, 1);
    check("rw_cnt", dut.cnt_q, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
